// File: rtl/bcast_fifo_pkg.sv
// Shared types and sizing helpers for the broadcast FIFO.
package bcast_fifo_pkg;

  typedef enum logic {
    OVF_BACKPRESSURE = 1'b0,
    OVF_DROP         = 1'b1
  } ovf_mode_e;

  localparam int DROP_CNT_W = 16;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bcast_fifo_if.sv
// Producer/subscriber bundle for bcast_fifo.
// Handshakes: a word moves on a rising edge where valid && ready are both high;
// valid never waits for ready, and data is only meaningful while valid is high.
interface bcast_fifo_if
  import bcast_fifo_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NUM_SUB = 4,
  parameter int DEPTH   = 8
);
  localparam int LW = ptr_w(DEPTH);

  logic                   wr_valid;
  logic [DW-1:0]          wr_data;
  logic                   wr_ready;
  logic [NUM_SUB-1:0]     sub_en;
  logic [NUM_SUB-1:0]     rd_valid;
  logic [NUM_SUB*DW-1:0]  rd_data;
  logic [NUM_SUB-1:0]     rd_ready;
  logic [LW-1:0]          level;
  logic [DROP_CNT_W-1:0]  drop_cnt;

  modport master (
    output wr_valid, wr_data, sub_en, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, drop_cnt
  );

  modport slave (
    input  wr_valid, wr_data, sub_en, rd_ready,
    output wr_ready, rd_valid, rd_data, level, drop_cnt
  );

endinterface

// File: rtl/bcast_fifo_rd_port.sv
// One subscriber read pointer; occupancy and valid derive purely from pointers.
module bcast_fifo_rd_port
  import bcast_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_sub_en,
  input  logic          i_rd_ready,
  input  logic [PW-1:0] i_wr_ptr,
  input  logic [PW-1:0] i_wr_ptr_next,
  output logic [AW-1:0] o_rd_idx,
  output logic [PW-1:0] o_cnt,
  output logic          o_rd_valid
);

  logic [PW-1:0] r_rd_ptr;
  logic          w_pop;

  assign o_cnt      = i_wr_ptr - r_rd_ptr;
  assign o_rd_valid = i_sub_en && (o_cnt != '0);
  assign o_rd_idx   = r_rd_ptr[AW-1:0];
  assign w_pop      = o_rd_valid && i_rd_ready;

  // A disabled port tracks the post-write pointer so it re-enables empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
    end else if (!i_sub_en) begin
      r_rd_ptr <= i_wr_ptr_next;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bcast_fifo.sv
// Single-writer broadcast FIFO: each word reaches every enabled subscriber once.
module bcast_fifo
  import bcast_fifo_pkg::*;
#(
  parameter int        DW       = 32,
  parameter int        DEPTH    = 8,
  parameter int        NUM_SUB  = 4,
  parameter ovf_mode_e OVF_MODE = OVF_BACKPRESSURE
) (
  input logic        clk,
  input logic        resetn,
  bcast_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [PW-1:0]         w_wr_ptr_next;
  logic [PW-1:0]         w_level;
  logic                  w_full;
  logic                  w_wr_fire;
  logic                  w_drop;
  logic [AW-1:0]         w_rd_idx [NUM_SUB];
  logic [PW-1:0]         w_cnt    [NUM_SUB];
  logic [NUM_SUB-1:0]    w_rd_valid;

  // Slowest enabled subscriber sets occupancy; disabled ones never hold the writer.
  always_comb begin
    w_level = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (bus.sub_en[i] && (w_cnt[i] > w_level)) begin
        w_level = w_cnt[i];
      end
    end
  end

  // Full is decided from registered state only, so pops never free a slot same-cycle.
  assign w_full        = (w_level == PW'(DEPTH));
  assign w_wr_fire     = bus.wr_valid && !w_full;
  assign w_drop        = (OVF_MODE == OVF_DROP) && bus.wr_valid && w_full;
  assign w_wr_ptr_next = r_wr_ptr + PW'(w_wr_fire);

  assign bus.wr_ready  = (OVF_MODE == OVF_DROP) ? 1'b1 : !w_full;
  assign bus.level     = w_level;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.rd_valid  = w_rd_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < NUM_SUB; g++) begin : g_port
    bcast_fifo_rd_port #(
      .DEPTH (DEPTH)
    ) u_port (
      .clk           (clk),
      .resetn        (resetn),
      .i_sub_en      (bus.sub_en[g]),
      .i_rd_ready    (bus.rd_ready[g]),
      .i_wr_ptr      (r_wr_ptr),
      .i_wr_ptr_next (w_wr_ptr_next),
      .o_rd_idx      (w_rd_idx[g]),
      .o_cnt         (w_cnt[g]),
      .o_rd_valid    (w_rd_valid[g])
    );

    assign bus.rd_data[g*DW +: DW] = r_mem[w_rd_idx[g]];
  end

endmodule

// File: tb/tb_bcast_fifo.sv
// Directed bench for bcast_fifo: one backpressure instance and one drop instance.
module tb_bcast_fifo;
  import bcast_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NS    = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bcast_fifo_if #(.DW(DW), .NUM_SUB(NS), .DEPTH(DEPTH)) bp_if ();
  bcast_fifo_if #(.DW(DW), .NUM_SUB(NS), .DEPTH(DEPTH)) dr_if ();

  bcast_fifo #(.DW(DW), .DEPTH(DEPTH), .NUM_SUB(NS), .OVF_MODE(OVF_BACKPRESSURE)) u_bp (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bp_if)
  );

  bcast_fifo #(.DW(DW), .DEPTH(DEPTH), .NUM_SUB(NS), .OVF_MODE(OVF_DROP)) u_dr (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dr_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bp_word(input int i);
    return bp_if.rd_data[i*DW +: DW];
  endfunction

  function automatic logic [31:0] dr_word(input int i);
    return dr_if.rd_data[i*DW +: DW];
  endfunction

  initial begin
    logic [DW-1:0] w;
    logic [NS-1:0] rdy;
    int            n;
    int            e [NS];

    bp_if.wr_valid = 1'b0; bp_if.wr_data = '0; bp_if.sub_en = 4'hF; bp_if.rd_ready = 4'hF;
    dr_if.wr_valid = 1'b0; dr_if.wr_data = '0; dr_if.sub_en = 4'hF; dr_if.rd_ready = 4'h0;

    // reset state
    #2;
    check("rst_level", 32'(bp_if.level), 32'd0);
    check("rst_wr_ready", 32'(bp_if.wr_ready), 32'd1);
    check("rst_rd_valid", 32'(bp_if.rd_valid), 32'd0);
    check("rst_drop_cnt", 32'(dr_if.drop_cnt), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // three words broadcast to four subscribers, one cycle latency
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      bp_if.wr_valid = 1'b1; bp_if.wr_data = w;
      tick();
      check("setup_valid", 32'(bp_if.rd_valid), 32'hF);
      for (int i = 0; i < NS; i++) check($sformatf("setup_data_p%0d", i), bp_word(i), w);
    end
    bp_if.wr_valid = 1'b0;
    tick();
    check("setup_level", 32'(bp_if.level), 32'd0);
    check("setup_empty", 32'(bp_if.rd_valid), 32'd0);

    // backpressure fill with subscriber 2 stalled
    bp_if.rd_ready = 4'b1011;
    for (int k = 1; k <= 8; k++) begin
      bp_if.wr_valid = 1'b1; bp_if.wr_data = 32'h100 + k;
      tick();
    end
    check("bp_level8", 32'(bp_if.level), 32'd8);
    check("bp_wr_ready0", 32'(bp_if.wr_ready), 32'd0);
    bp_if.wr_data = 32'h109;
    tick();
    check("bp_hold_level", 32'(bp_if.level), 32'd8);
    check("bp_hold_ready", 32'(bp_if.wr_ready), 32'd0);
    check("bp_p2_head", bp_word(2), 32'h101);
    bp_if.rd_ready = 4'b1111;
    tick();
    bp_if.rd_ready = 4'b1011;
    check("bp_ready_after_pop", 32'(bp_if.wr_ready), 32'd1);
    check("bp_level7", 32'(bp_if.level), 32'd7);
    check("bp_p2_next", bp_word(2), 32'h102);
    tick();
    bp_if.wr_valid = 1'b0;
    check("bp_9th_level", 32'(bp_if.level), 32'd8);
    check("bp_9th_ready", 32'(bp_if.wr_ready), 32'd0);
    check("bp_p0_9th", bp_word(0), 32'h109);
    bp_if.rd_ready = 4'hF;
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("bp_drain_%0d", k), bp_word(2), 32'h100 + k);
      tick();
    end
    check("bp_drained", 32'(bp_if.level), 32'd0);

    // late enable: subscriber 3 sees only words written after enabling
    bp_if.sub_en = 4'b0111;
    for (int k = 1; k <= 5; k++) begin
      bp_if.wr_valid = 1'b1; bp_if.wr_data = 32'h200 + k;
      tick();
      check("en_p3_idle", 32'(bp_if.rd_valid[3]), 32'd0);
    end
    bp_if.wr_valid = 1'b0; bp_if.sub_en = 4'hF;
    #1;
    check("en_first_cycle", 32'(bp_if.rd_valid), 32'b0111);
    tick();
    bp_if.wr_valid = 1'b1; bp_if.wr_data = 32'h206;
    tick();
    bp_if.wr_valid = 1'b0;
    check("en_valid_all", 32'(bp_if.rd_valid), 32'hF);
    check("en_p3_data", bp_word(3), 32'h206);
    tick();
    check("en_level0", 32'(bp_if.level), 32'd0);

    // disable the slowest subscriber with six words pending
    bp_if.rd_ready = 4'b1101;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) bp_if.rd_ready = 4'b0101;
      bp_if.wr_valid = 1'b1; bp_if.wr_data = 32'h300 + k;
      tick();
    end
    bp_if.wr_valid = 1'b0;
    check("dis_level6", 32'(bp_if.level), 32'd6);
    check("dis_p3_head", bp_word(3), 32'h304);
    bp_if.sub_en = 4'b1101;
    tick();
    check("dis_level3", 32'(bp_if.level), 32'd3);
    check("dis_valid", 32'(bp_if.rd_valid), 32'b1000);
    bp_if.sub_en = 4'hF; bp_if.rd_ready = 4'hF;
    tick(); tick(); tick();
    check("dis_drained", 32'(bp_if.level), 32'd0);

    // wrap: 3*DEPTH words with staggered per-port ready
    n = 0;
    for (int i = 0; i < NS; i++) e[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (n == 3*DEPTH && e[0] == 3*DEPTH && e[1] == 3*DEPTH &&
          e[2] == 3*DEPTH && e[3] == 3*DEPTH) break;
      for (int i = 0; i < NS; i++) rdy[i] = ((cyc + i) % (i + 2)) != 0;
      bp_if.rd_ready = rdy;
      bp_if.wr_valid = (n < 3*DEPTH);
      bp_if.wr_data  = 32'h400 + n;
      #1;
      for (int i = 0; i < NS; i++) begin
        if (bp_if.rd_valid[i] && rdy[i]) begin
          check($sformatf("wrap_p%0d_w%0d", i, e[i]), bp_word(i), 32'h400 + e[i]);
          e[i]++;
        end
      end
      if (bp_if.wr_valid && bp_if.wr_ready) n++;
      tick();
    end
    bp_if.wr_valid = 1'b0; bp_if.rd_ready = 4'hF;
    check("wrap_written", 32'(n), 32'(3*DEPTH));
    for (int i = 0; i < NS; i++) check($sformatf("wrap_count_p%0d", i), 32'(e[i]), 32'(3*DEPTH));
    check("wrap_level0", 32'(bp_if.level), 32'd0);

    // drop mode: 12 writes into 8 slots, no reads
    for (int k = 1; k <= 12; k++) begin
      dr_if.wr_valid = 1'b1; dr_if.wr_data = 32'h600 + k;
      if (k == 12) check("drop_wr_ready_full", 32'(dr_if.wr_ready), 32'd1);
      tick();
    end
    dr_if.wr_valid = 1'b0;
    check("drop_cnt4", 32'(dr_if.drop_cnt), 32'd4);
    check("drop_level8", 32'(dr_if.level), 32'd8);
    dr_if.rd_ready = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drop_p0_%0d", k), dr_word(0), 32'h600 + k);
      check($sformatf("drop_p3_%0d", k), dr_word(3), 32'h600 + k);
      tick();
    end
    check("drop_drained", 32'(dr_if.level), 32'd0);
    dr_if.rd_ready = 4'h0; dr_if.wr_valid = 1'b1;
    repeat (DEPTH + 70000) tick();
    dr_if.wr_valid = 1'b0;
    check("drop_saturate", 32'(dr_if.drop_cnt), 32'hFFFF);

    // reset mid-operation
    bp_if.rd_ready = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      bp_if.wr_valid = 1'b1; bp_if.wr_data = 32'h500 + k;
      tick();
    end
    bp_if.wr_data = 32'h506;
    check("mid_level5", 32'(bp_if.level), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bp_if.rd_valid), 32'd0);
    check("mid_rst_level", 32'(bp_if.level), 32'd0);
    check("mid_rst_wr_ready", 32'(bp_if.wr_ready), 32'd1);
    check("mid_rst_drop_cnt", 32'(dr_if.drop_cnt), 32'd0);
    check("mid_rst_dr_level", 32'(dr_if.level), 32'd0);
    tick();
    resetn = 1'b1;
    bp_if.wr_data = 32'h5AA; bp_if.rd_ready = 4'hF;
    tick();
    bp_if.wr_valid = 1'b0;
    check("post_rst_valid", 32'(bp_if.rd_valid), 32'hF);
    for (int i = 0; i < NS; i++) check($sformatf("post_rst_p%0d", i), bp_word(i), 32'h5AA);
    tick();
    check("post_rst_level", 32'(bp_if.level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
